vga_sync_gen: RTL and testbench

Raster timing generator for the VGA path. It divides the system clock into a pixel-rate enable and runs horizontal and vertical position counters. From those counters it produces `hsync_o`, `vsync_o`, `disp_active_o` and the `xcol_o`/`yrow_o` pixel coordinates. The downstream pattern/colour stage consumes these on the same clock, and the syncs go to the VGA connector. Defaults give 640x480@60 Hz from a 100 MHz clock.

---
 rtl/vga_pkg.sv | 27 ++
 rtl/clk_en_div.sv | 35 +++
 rtl/vga_sync_gen.sv | 118 +++++++++++
 tb/tb_vga_sync_gen.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing constants, coordinate type and window helper.
// Defaults describe 640x480@60 Hz from a 100 MHz system clock.
package vga_pkg;

  localparam int COORD_W   = 10;
  localparam int MAX_TOTAL = 1 << COORD_W;

  typedef logic [COORD_W-1:0] coord_t;

  localparam int VGA_CLK_DIV   = 4;
  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;
  localparam int VGA_V_VISIBLE = 480;
  localparam int VGA_V_FRONT   = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BACK    = 33;

  localparam bit HS_POL_DEF = 1'b0;
  localparam bit VS_POL_DEF = 1'b0;

  function automatic logic in_win(coord_t p, int lo, int hi);
    return (int'(p) >= lo) && (int'(p) < hi);
  endfunction

endpackage

// File: rtl/clk_en_div.sv
// Divides the system clock into a registered one-cycle enable.
// The enable is high for one clock out of every CLK_DIV.
module clk_en_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic tick_o
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  if (CLK_DIV < 1) begin : g_bad_div
    $error("clk_en_div: CLK_DIV must be >= 1");
  end

  logic [CW-1:0] div_q, div_d;
  logic          tick_q;

  assign div_d = (div_q == LAST) ? '0 : div_q + 1'b1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      tick_q <= (div_q == LAST);
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/vga_sync_gen.sv
// Raster position counters with registered sync/active decode.
// Decode is taken from the next position so all outputs stay aligned.
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV   = VGA_CLK_DIV,
  parameter int H_VISIBLE = VGA_H_VISIBLE,
  parameter int H_FRONT   = VGA_H_FRONT,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BACK    = VGA_H_BACK,
  parameter int V_VISIBLE = VGA_V_VISIBLE,
  parameter int V_FRONT   = VGA_V_FRONT,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BACK    = VGA_V_BACK,
  parameter bit HS_POL    = HS_POL_DEF,
  parameter bit VS_POL    = VS_POL_DEF
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  output logic         pix_tick_o,
  output logic         hsync_o,
  output logic         vsync_o,
  output logic         disp_active_o,
  output logic [9:0]   xcol_o,
  output logic [9:0]   yrow_o,
  output logic         line_start_o,
  output logic         frame_start_o
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_LO   = H_VISIBLE + H_FRONT;
  localparam int HS_HI   = HS_LO + H_SYNC;
  localparam int VS_LO   = V_VISIBLE + V_FRONT;
  localparam int VS_HI   = VS_LO + V_SYNC;

  localparam coord_t H_MAX = coord_t'(H_TOTAL - 1);
  localparam coord_t V_MAX = coord_t'(V_TOTAL - 1);

  if (H_TOTAL > MAX_TOTAL) begin : g_bad_h
    $error("vga_sync_gen: H_TOTAL exceeds coordinate range");
  end
  if (V_TOTAL > MAX_TOTAL) begin : g_bad_v
    $error("vga_sync_gen: V_TOTAL exceeds coordinate range");
  end

  logic   tick;
  coord_t x_q, x_d;
  coord_t y_q, y_d;
  logic   hs_q, hs_d;
  logic   vs_q, vs_d;
  logic   de_q, de_d;
  logic   ls_q, ls_d;
  logic   fs_q, fs_d;
  logic   h_wrap;

  clk_en_div #(
    .CLK_DIV (CLK_DIV)
  ) u_div (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .tick_o (tick)
  );

  assign h_wrap = tick && (x_q == H_MAX);

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (tick) begin
      if (x_q == H_MAX) begin
        x_d = '0;
        y_d = (y_q == V_MAX) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_comb begin
    hs_d = in_win(x_d, HS_LO, HS_HI) ? HS_POL : !HS_POL;
    vs_d = in_win(y_d, VS_LO, VS_HI) ? VS_POL : !VS_POL;
    de_d = in_win(x_d, 0, H_VISIBLE) && in_win(y_d, 0, V_VISIBLE);
    ls_d = h_wrap;
    fs_d = h_wrap && (y_q == V_MAX);
  end

  // Reset parks on the last raster position so the first tick lands on (0,0).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_q  <= H_MAX;
      y_q  <= V_MAX;
      hs_q <= !HS_POL;
      vs_q <= !VS_POL;
      de_q <= 1'b0;
      ls_q <= 1'b0;
      fs_q <= 1'b0;
    end else begin
      x_q  <= x_d;
      y_q  <= y_d;
      hs_q <= hs_d;
      vs_q <= vs_d;
      de_q <= de_d;
      ls_q <= ls_d;
      fs_q <= fs_d;
    end
  end

  assign pix_tick_o    = tick;
  assign hsync_o       = hs_q;
  assign vsync_o       = vs_q;
  assign disp_active_o = de_q;
  assign xcol_o        = x_q;
  assign yrow_o        = y_q;
  assign line_start_o  = ls_q;
  assign frame_start_o = fs_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: default 640x480 timing, a tiny raster for whole-frame
// checks, and a CLK_DIV=1 / positive-hsync variant.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       tk0, hs0, vs0, de0, ls0, fs0;
  logic [9:0] x0, y0;
  logic       tk1, hs1, vs1, de1, ls1, fs1;
  logic [9:0] x1, y1;
  logic       tk2, hs2, vs2, de2, ls2, fs2;
  logic [9:0] x2, y2;

  vga_sync_gen u0 (
    .clk_i(clk), .rst_ni(rst_n), .pix_tick_o(tk0),
    .hsync_o(hs0), .vsync_o(vs0), .disp_active_o(de0),
    .xcol_o(x0), .yrow_o(y0),
    .line_start_o(ls0), .frame_start_o(fs0)
  );

  // 15 x 10 raster, 2 clocks per pixel: frame = 300 clocks
  vga_sync_gen #(
    .CLK_DIV(2),
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
  ) u1 (
    .clk_i(clk), .rst_ni(rst_n), .pix_tick_o(tk1),
    .hsync_o(hs1), .vsync_o(vs1), .disp_active_o(de1),
    .xcol_o(x1), .yrow_o(y1),
    .line_start_o(ls1), .frame_start_o(fs1)
  );

  vga_sync_gen #(
    .CLK_DIV(1), .HS_POL(1'b1)
  ) u2 (
    .clk_i(clk), .rst_ni(rst_n), .pix_tick_o(tk2),
    .hsync_o(hs2), .vsync_o(vs2), .disp_active_o(de2),
    .xcol_o(x2), .yrow_o(y2),
    .line_start_o(ls2), .frame_start_o(fs2)
  );

  int passed = 0;
  int total  = 0;
  int e      = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic go_to(input int target);
    while (e < target) begin
      @(negedge clk);
      e++;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " x0"},  x0, 799);
    chk({tag, " y0"},  y0, 524);
    chk({tag, " hs0"}, hs0, 1);
    chk({tag, " vs0"}, vs0, 1);
    chk({tag, " de0"}, de0, 0);
    chk({tag, " tk0"}, tk0, 0);
    chk({tag, " ls0"}, ls0, 0);
    chk({tag, " fs0"}, fs0, 0);
    chk({tag, " x1"},  x1, 14);
    chk({tag, " y1"},  y1, 9);
    chk({tag, " hs2"}, hs2, 0);
    chk({tag, " tk2"}, tk2, 0);
  endtask

  task automatic chk_startup(input string tag);
    go_to(1);
    chk({tag, " tk2 e1"}, tk2, 1);
    chk({tag, " tk0 e1"}, tk0, 0);
    go_to(3);
    chk({tag, " tk0 e3"}, tk0, 0);
    chk({tag, " x0 e3"},  x0, 799);
    go_to(4);
    chk({tag, " tk0 e4"}, tk0, 1);
    chk({tag, " fs0 e4"}, fs0, 0);
    go_to(5);
    chk({tag, " tk0 e5"}, tk0, 0);
    chk({tag, " x0 e5"},  x0, 0);
    chk({tag, " y0 e5"},  y0, 0);
    chk({tag, " fs0 e5"}, fs0, 1);
    chk({tag, " ls0 e5"}, ls0, 1);
    chk({tag, " de0 e5"}, de0, 1);
    chk({tag, " hs0 e5"}, hs0, 1);
    go_to(6);
    chk({tag, " fs0 e6"}, fs0, 0);
    chk({tag, " ls0 e6"}, ls0, 0);
    chk({tag, " x0 e6"},  x0, 0);
  endtask

  initial begin
    int first_x, last_x, lo_cnt, tick_cnt;

    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    rst_n = 1'b1;
    e = 0;
    chk_startup("start");

    go_to(8);
    chk("tk0 e8", tk0, 1);
    go_to(9);
    chk("tk0 e9", tk0, 0);
    chk("x0 e9", x0, 1);

    tick_cnt = 0;
    while (e < 209) begin
      go_to(e + 1);
      if (tk2 === 1'b1) tick_cnt++;
    end
    chk("tk2 const", tick_cnt, 200);

    go_to(211);
    chk("x1 p104", x1, 14);
    chk("y1 p104", y1, 6);
    chk("vs1 y6", vs1, 1);
    go_to(213);
    chk("x1 p105", x1, 0);
    chk("y1 p105", y1, 7);
    chk("vs1 y7", vs1, 0);
    chk("ls1 p105", ls1, 1);
    go_to(271);
    chk("vs1 y8 end", vs1, 0);
    go_to(273);
    chk("y1 p135", y1, 9);
    chk("vs1 y9", vs1, 1);
    go_to(301);
    chk("x1 last", x1, 14);
    chk("y1 last", y1, 9);
    chk("fs1 last", fs1, 0);
    go_to(303);
    chk("x1 wrap", x1, 0);
    chk("y1 wrap", y1, 0);
    chk("fs1 wrap", fs1, 1);
    chk("de1 wrap", de1, 1);
    go_to(304);
    chk("fs1 1clk", fs1, 0);

    go_to(657);
    chk("x2 655", x2, 655);
    chk("hs2 655", hs2, 0);
    go_to(658);
    chk("hs2 656", hs2, 1);
    go_to(753);
    chk("hs2 751", hs2, 1);
    go_to(754);
    chk("hs2 752", hs2, 0);
    go_to(801);
    chk("ls2 799", ls2, 0);
    go_to(802);
    chk("ls2 line", ls2, 1);
    chk("x2 line", x2, 0);
    chk("y2 line", y2, 1);

    go_to(2564);
    chk("x0 639", x0, 639);
    chk("de0 639", de0, 1);
    go_to(2565);
    chk("x0 640", x0, 640);
    chk("de0 640", de0, 0);

    first_x = -1;
    last_x  = -1;
    lo_cnt  = 0;
    while (e < 3201) begin
      go_to(e + 1);
      if (hs0 === 1'b0) begin
        lo_cnt++;
        if (first_x < 0) first_x = int'(x0);
        last_x = int'(x0);
      end
    end
    chk("hs0 lo clocks", lo_cnt, 384);
    chk("hs0 lo first", first_x, 656);
    chk("hs0 lo last", last_x, 751);
    chk("x0 799", x0, 799);
    chk("y0 799", y0, 0);
    go_to(3205);
    chk("x0 wrap", x0, 0);
    chk("y0 wrap", y0, 1);
    chk("ls0 wrap", ls0, 1);
    chk("fs0 wrap", fs0, 0);
    go_to(3206);
    chk("ls0 1clk", ls0, 0);

    go_to(4405);
    chk("x0 mid", x0, 300);
    chk("y0 mid", y0, 1);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("async");
    @(negedge clk);
    chk_reset_vals("held");
    rst_n = 1'b1;
    e = 0;
    chk_startup("restart");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
